// File: rtl/cfo_mem_sequencer_pkg.sv
// Shared types and constants for the CFO sample-memory read sequencer.
// Holds the FSM state encoding, default geometry and the request range check.
package cfo_mem_sequencer_pkg;

    localparam int DEPTH_DEFAULT = 1280;
    localparam int AW_DEFAULT    = 12;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // A request is legal when it reads something and its furthest word stays inside the bank.
    function automatic logic range_ok(input logic [31:0] end_addr,
                                      input logic [31:0] len,
                                      input logic [31:0] depth);
        return (len != 32'd0) && (end_addr <= depth);
    endfunction

endpackage

// File: rtl/cfo_mem_sequencer_rd_align.sv
// Registers the issue flags by one cycle so they line up with the banks' registered read data.
module cfo_mem_sequencer_rd_align (
    input  logic clk,
    input  logic rst,
    input  logic issue_valid,
    input  logic issue_first,
    input  logic issue_last,
    output logic rd_valid,
    output logic rd_first,
    output logic rd_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= issue_valid;
            rd_first <= issue_first;
            rd_last  <= issue_last;
        end
    end

endmodule

// File: rtl/cfo_mem_sequencer.sv
// Burst read sequencer driving the shared address/offset/mode of the real and imaginary banks,
// with range checking of each request and valid/first/last strobes aligned to the read data.
module cfo_mem_sequencer
    import cfo_mem_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pair,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] lag,
    input  logic [AW-1:0] length,
    input  logic          pause,
    output logic          mode,
    output logic [AW-1:0] address,
    output logic [AW-1:0] offset,
    output logic          rd_valid,
    output logic          rd_first,
    output logic          rd_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state, state_next;
    logic [AW-1:0] base_q, lag_q, len_q, cnt;
    logic [AW-1:0] addr_hold, off_hold;
    logic          pair_q;
    logic [AW:0]   end_addr;
    logic          accept_ok;
    logic          issue, issue_first, issue_last, last_issue;

    assign end_addr   = {1'b0, base_q} + {1'b0, len_q} + {1'b0, lag_q};
    assign accept_ok  = range_ok(32'(end_addr), 32'(len_q), 32'(DEPTH));
    assign last_issue = (cnt == len_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = accept_ok ? RUN : IDLE;
            RUN:     if (issue && last_issue) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outside RUN the bank inputs replay the last issued address/offset with mode forced low.
    always_comb begin
        issue       = (state == RUN) && !pause;
        issue_first = issue && (cnt == '0);
        issue_last  = issue && last_issue;
        mode        = (state == RUN) && pair_q;
        address     = (state == RUN) ? base_q + cnt : addr_hold;
        offset      = (state == RUN) ? lag_q : off_hold;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            lag_q     <= '0;
            len_q     <= '0;
            pair_q    <= 1'b0;
            cnt       <= '0;
            addr_hold <= '0;
            off_hold  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= (state == DONE);
            err  <= (state == CHECK) && !accept_ok;
            if (state == IDLE && start) begin
                base_q <= base;
                lag_q  <= pair ? lag : '0;
                len_q  <= length;
                pair_q <= pair;
            end
            if (state == CHECK) begin
                cnt <= '0;
            end
            if (state == RUN) begin
                addr_hold <= base_q + cnt;
                off_hold  <= lag_q;
                if (!pause) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    cfo_mem_sequencer_rd_align u_rd_align (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue),
        .issue_first (issue_first),
        .issue_last  (issue_last),
        .rd_valid    (rd_valid),
        .rd_first    (rd_first),
        .rd_last     (rd_last)
    );

endmodule

// File: tb/tb_cfo_mem_sequencer.sv
// Bench for cfo_mem_sequencer: a behavioural bank model feeds read data back, and each burst is
// compared against timings and sample order derived directly from the burst parameters.
module tb_cfo_mem_sequencer;

    localparam int AW    = 12;
    localparam int DEPTH = 1280;

    logic          clk = 1'b0;
    logic          rst, start, pair, pause;
    logic [AW-1:0] base, lag, length;
    logic          mode;
    logic [AW-1:0] address, offset;
    logic          rd_valid, rd_first, rd_last, busy, done, err;

    cfo_mem_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pair     (pair),
        .base     (base),
        .lag      (lag),
        .length   (length),
        .pause    (pause),
        .mode     (mode),
        .address  (address),
        .offset   (offset),
        .rd_valid (rd_valid),
        .rd_first (rd_first),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Bank model: one-cycle registered read of address and address+offset.
    logic [15:0] mem [0:8191];
    logic [15:0] out_a, out_b;
    logic        out_mode;
    always @(posedge clk) begin
        out_a    <= mem[13'(address)];
        out_b    <= mem[13'(address) + 13'(offset)];
        out_mode <= mode;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int valid_total = 0, done_total = 0, err_total = 0, busy_total = 0;
    int first_cyc = -1, done_cyc = -1, err_cyc = -1;
    int obs_a[$], obs_b[$], obs_mode[$], obs_first[$], obs_last[$];

    always @(negedge clk) begin
        if (rd_valid) begin
            valid_total++;
            obs_a.push_back(int'(out_a));
            obs_b.push_back(int'(out_b));
            obs_mode.push_back(int'(out_mode));
            obs_first.push_back(int'(rd_first));
            obs_last.push_back(int'(rd_last));
            if (rd_first) first_cyc = cyc;
        end
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
        if (err) begin
            err_total++;
            err_cyc = cyc;
        end
        if (busy) busy_total++;
    end

    int compared = 0, mismatched = 0;
    int k, snap_valid, snap_done, snap_err, snap_busy, snap_q;
    bit timed_out;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int b, input int l, input int n, input bit p,
                                 input int pstart, input int plen, input int again_at);
        snap_valid = valid_total;
        snap_done  = done_total;
        snap_err   = err_total;
        snap_busy  = busy_total;
        snap_q     = obs_a.size();
        @(posedge clk); #1;
        base   = AW'(b);
        lag    = AW'(l);
        length = AW'(n);
        pair   = p;
        start  = 1'b1;
        k      = cyc;
        timed_out = 1'b1;
        for (int t = 1; t < 600; t++) begin
            @(posedge clk); #1;
            start = (t == again_at);
            pause = (t >= pstart) && (t < pstart + plen);
            if (done_total != snap_done || err_total != snap_err) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        pause = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic checkBurst(input string tag, input int b, input int l, input int n,
                              input bit p, input int plen, input bit expect_ok);
        int eff_lag, idx;
        eff_lag = p ? l : 0;
        checkOutput({tag, ".timeout"}, int'(timed_out), 0);
        if (expect_ok) begin
            checkOutput({tag, ".valid_cnt"}, valid_total - snap_valid, n);
            checkOutput({tag, ".done_cnt"}, done_total - snap_done, 1);
            checkOutput({tag, ".err_cnt"}, err_total - snap_err, 0);
            checkOutput({tag, ".first_lat"}, first_cyc - k, 3);
            checkOutput({tag, ".done_lat"}, done_cyc - k, n + 4 + plen);
            checkOutput({tag, ".busy_cyc"}, busy_total - snap_busy, n + 3 + plen);
            for (int i = 0; i < n; i++) begin
                idx = snap_q + i;
                if (idx < obs_a.size()) begin
                    checkOutput($sformatf("%s.re[%0d]", tag, i), obs_a[idx], int'(mem[b + i]));
                    checkOutput($sformatf("%s.lagged[%0d]", tag, i), obs_b[idx],
                                int'(mem[b + eff_lag + i]));
                    checkOutput($sformatf("%s.mode[%0d]", tag, i), obs_mode[idx], int'(p));
                    checkOutput($sformatf("%s.first[%0d]", tag, i), obs_first[idx], int'(i == 0));
                    checkOutput($sformatf("%s.last[%0d]", tag, i), obs_last[idx], int'(i == n - 1));
                end
            end
        end else begin
            checkOutput({tag, ".err_cnt"}, err_total - snap_err, 1);
            checkOutput({tag, ".err_lat"}, err_cyc - k, 2);
            checkOutput({tag, ".valid_cnt"}, valid_total - snap_valid, 0);
            checkOutput({tag, ".done_cnt"}, done_total - snap_done, 0);
            checkOutput({tag, ".busy_cyc"}, busy_total - snap_busy, 1);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".address"}, int'(address), 0);
        checkOutput({tag, ".offset"}, int'(offset), 0);
        checkOutput({tag, ".mode"}, int'(mode), 0);
        checkOutput({tag, ".rd_valid"}, int'(rd_valid), 0);
        checkOutput({tag, ".rd_first"}, int'(rd_first), 0);
        checkOutput({tag, ".rd_last"}, int'(rd_last), 0);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".done"}, int'(done), 0);
        checkOutput({tag, ".err"}, int'(err), 0);
    endtask

    initial begin
        int rb, rl, rn, rps, rpl, reff;
        bit rp;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        rst = 1'b1; start = 1'b0; pair = 1'b0; pause = 1'b0;
        base = '0; lag = '0; length = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(0, 0, 4, 1'b0, 0, 0, 0);
        checkBurst("single", 0, 0, 4, 1'b0, 0, 1'b1);

        applyStimulus(100, 16, 64, 1'b1, 0, 0, 0);
        checkBurst("pair", 100, 16, 64, 1'b1, 0, 1'b1);

        applyStimulus(1200, 16, 64, 1'b1, 0, 0, 0);
        checkBurst("edge_ok", 1200, 16, 64, 1'b1, 0, 1'b1);
        applyStimulus(1200, 16, 65, 1'b1, 0, 0, 0);
        checkBurst("edge_over", 1200, 16, 65, 1'b1, 0, 1'b0);

        applyStimulus(300, 0, 8, 1'b0, 4, 3, 0);
        checkBurst("pause", 300, 0, 8, 1'b0, 3, 1'b1);

        applyStimulus(40, 0, 0, 1'b0, 0, 0, 0);
        checkBurst("zero_len", 40, 0, 0, 1'b0, 0, 1'b0);

        applyStimulus(500, 8, 16, 1'b1, 0, 0, 6);
        checkBurst("start_busy", 500, 8, 16, 1'b1, 0, 1'b1);

        // Lag must be ignored for single reads, so this request just fits the bank.
        applyStimulus(1200, 200, 80, 1'b0, 0, 0, 0);
        checkBurst("lag_ignored", 1200, 200, 80, 1'b0, 0, 1'b1);

        snap_valid = valid_total;
        @(posedge clk); #1;
        base = AW'(20); lag = AW'(5); length = AW'(32); pair = 1'b1; start = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_mid.valid_before", valid_total - snap_valid, 5);
        checkIdleOutputs("rst_mid");
        snap_valid = valid_total;
        snap_done  = done_total;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_mid.valid_after", valid_total - snap_valid, 0);
        checkOutput("rst_mid.done_after", done_total - snap_done, 0);

        applyStimulus(20, 5, 32, 1'b1, 0, 0, 0);
        checkBurst("after_rst", 20, 5, 32, 1'b1, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            rp   = 1'($urandom_range(0, 1));
            rn   = int'($urandom_range(1, 48));
            rl   = int'($urandom_range(0, 40));
            reff = rp ? rl : 0;
            rb   = int'($urandom_range(0, DEPTH - rn - reff));
            rpl  = int'($urandom_range(0, 2));
            rps  = int'($urandom_range(2, rn + 1));
            applyStimulus(rb, rl, rn, rp, rps, rpl, 0);
            checkBurst($sformatf("rand%0d", r), rb, rl, rn, rp, rpl, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
